// File: rtl/fft_share_arbiter.sv
// Two-requester arbiter sharing one FFT core; a tag FIFO routes results back in issue order.
// Optional per-requester frame counters are enabled with macro FFT_ARB_STATS_EN.
module fft_share_arbiter #(
    parameter int NPOINT    = 2,
    parameter int WIDTH     = 16,
    parameter int TAG_DEPTH = 4,
    localparam int F        = WIDTH * (2 ** NPOINT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_busy,
    input  logic [F-1:0] req0_real,
    input  logic [F-1:0] req0_imag,
    input  logic         req1_valid,
    output logic         req1_busy,
    input  logic [F-1:0] req1_real,
    input  logic [F-1:0] req1_imag,
    output logic         fft_din_valid,
    input  logic         fft_din_busy,
    output logic [F-1:0] fft_din_real,
    output logic [F-1:0] fft_din_imag,
    input  logic         fft_dout_valid,
    output logic         fft_dout_busy,
    input  logic [F-1:0] fft_dout_real,
    input  logic [F-1:0] fft_dout_imag,
    output logic         rsp0_valid,
    input  logic         rsp0_busy,
    output logic [F-1:0] rsp0_real,
    output logic [F-1:0] rsp0_imag,
    output logic         rsp1_valid,
    input  logic         rsp1_busy,
    output logic [F-1:0] rsp1_real,
    output logic [F-1:0] rsp1_imag,
    output logic         err_orphan
`ifdef FFT_ARB_STATS_EN
    ,
    output logic [15:0]  stat_frames0,
    output logic [15:0]  stat_frames1
`endif
);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;

    logic                 ptr_q, ptr_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 gnt_s, push_s, pop_s, head_s, tag_full_s, tag_empty_s;

    assign err_orphan = err_q;

    // Grant, FFT input mux, result demux and the transfer strobes derived from them.
    always_comb begin
        tag_full_s    = (cnt_q == CW'(TAG_DEPTH));
        tag_empty_s   = (cnt_q == {CW{1'b0}});
        gnt_s         = (req0_valid & req1_valid) ? ptr_q : req1_valid;
        head_s        = tag_q[rd_q];
        fft_din_valid = (req0_valid | req1_valid) & ~tag_full_s;
        fft_din_real  = {F{1'b0}};
        fft_din_imag  = {F{1'b0}};
        fft_dout_busy = 1'b0;
        rsp0_valid    = 1'b0;
        rsp0_real     = {F{1'b0}};
        rsp0_imag     = {F{1'b0}};
        rsp1_valid    = 1'b0;
        rsp1_real     = {F{1'b0}};
        rsp1_imag     = {F{1'b0}};
        if (req0_valid | req1_valid) begin
            fft_din_real = gnt_s ? req1_real : req0_real;
            fft_din_imag = gnt_s ? req1_imag : req0_imag;
        end else begin
            fft_din_real = {F{1'b0}};
        end
        req0_busy = gnt_s ? 1'b1 : (fft_din_busy | tag_full_s);
        req1_busy = gnt_s ? (fft_din_busy | tag_full_s) : 1'b1;
        if (!tag_empty_s) begin
            if (head_s) begin
                rsp1_valid    = fft_dout_valid;
                rsp1_real     = fft_dout_real;
                rsp1_imag     = fft_dout_imag;
                fft_dout_busy = rsp1_busy;
            end else begin
                rsp0_valid    = fft_dout_valid;
                rsp0_real     = fft_dout_real;
                rsp0_imag     = fft_dout_imag;
                fft_dout_busy = rsp0_busy;
            end
        end else begin
            fft_dout_busy = 1'b0;
        end
        push_s = fft_din_valid & ~fft_din_busy;
        pop_s  = ~tag_empty_s & fft_dout_valid & ~fft_dout_busy;
    end

    // Next-state for priority pointer, tag FIFO and the orphan flag.
    always_comb begin
        ptr_d = ptr_q;
        tag_d = tag_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        err_d = err_q | (tag_empty_s & fft_dout_valid);
        if (push_s) begin
            ptr_d        = ~gnt_s;
            tag_d[wr_q]  = gnt_s;
            wr_d         = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
            tag_q <= {TAG_DEPTH{1'b0}};
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= {CW{1'b0}};
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            tag_q <= tag_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef FFT_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d, stat1_q, stat1_d;

    assign stat_frames0 = stat0_q;
    assign stat_frames1 = stat1_q;

    // Saturating per-requester accepted-frame counters.
    always_comb begin
        stat0_d = stat0_q;
        stat1_d = stat1_q;
        if (push_s && !gnt_s && stat0_q != 16'hFFFF) begin
            stat0_d = stat0_q + 16'd1;
        end else if (push_s && gnt_s && stat1_q != 16'hFFFF) begin
            stat1_d = stat1_q + 16'd1;
        end else begin
            stat0_d = stat0_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat0_q <= 16'd0;
            stat1_q <= 16'd0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end
`endif

endmodule

// File: doc/fft_share_arbiter.md
FFT_SHARE_ARBITER -- requirements
Module: fft_share_arbiter

Interface
REQ-001 The block SHALL have parameters: NPOINT, default 2, log2 of FFT points; WIDTH, default 16, bits per real/imag sample; TAG_DEPTH, default 4, maximum frames in flight (power of two, at least 2).
REQ-002 The block SHALL have these ports, with F = WIDTH*(2**NPOINT):
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- reqK_valid  in  1  frame offered by requester K (K=0,1)
- reqK_busy  out  1  arbiter cannot accept from K
- reqK_real, reqK_imag  in  F  requester K frame
- fft_din_valid  out  1  frame to FFT
- fft_din_busy  in  1  FFT not ready
- fft_din_real, fft_din_imag  out  F  frame to FFT
- fft_dout_valid  in  1  FFT result valid
- fft_dout_busy  out  1  backpressure to FFT
- fft_dout_real, fft_dout_imag  in  F  FFT result
- rspK_valid  out  1  result for requester K
- rspK_busy  in  1  requester K not ready
- rspK_real, rspK_imag  out  F  result for K
- err_orphan  out  1  sticky: result arrived with no frame outstanding
REQ-003 Clock and reset SHALL be exactly as stated in REQ-002: one clock clk; reset rst is synchronous and active-high.

Function
REQ-004 A transfer on any valid/busy pair SHALL occur on a rising clk edge where valid=1 and busy=0; valid and data SHALL be held until transfer.
REQ-005 Grant selection SHALL be combinational (0-cycle request-to-FFT path): if exactly one requester is valid, grant it; if both are valid, grant the requester selected by the 1-bit priority pointer ptr.
REQ-006 fft_din_valid SHALL equal (req0_valid|req1_valid) & !tag_full; fft_din_real and fft_din_imag SHALL carry the granted requester's data, or zero when none is granted.
REQ-007 The granted requester's reqK_busy SHALL equal fft_din_busy|tag_full; the non-granted requester's busy SHALL be 1.
REQ-008 On each FFT input transfer, the arbiter SHALL push the granted ID onto a TAG_DEPTH-entry tag FIFO and set ptr to the ID that was not granted; ptr SHALL remain unchanged otherwise.
REQ-009 When the tag FIFO is full, no push SHALL occur, even if a pop happens in the same cycle; when it is not full, push and pop in the same cycle SHALL both take effect and occupancy SHALL stay unchanged.
REQ-010 When the FIFO is non-empty with head tag H: rspH_valid=fft_dout_valid; rspH data=fft_dout data; the other rsp valid=0; fft_dout_busy=rspH_busy.
REQ-011 A pop SHALL occur on each rspH transfer, and results SHALL be routed in strict FIFO order.
REQ-012 When the FIFO is empty: fft_dout_busy=0 (result consumed and discarded), both rsp valids=0, and err_orphan SHALL set to 1 on any fft_dout_valid and hold until reset.
REQ-013 Read and write pointers SHALL wrap modulo TAG_DEPTH; occupancy SHALL be tracked with log2(TAG_DEPTH)+1 bits.
REQ-014 Outputs not driven by a live mux path SHALL be 0.

Reset
REQ-015 While rst=1 at a clock edge: ptr=0, FIFO empty, err_orphan=0, and stats counters=0.
REQ-016 Combinational outputs after reset SHALL follow REQ-006..REQ-012 with an empty FIFO: reqK_busy per REQ-007, fft_dout_busy=0, and rspK_valid=0.
REQ-017 Reset mid-operation SHALL drop all outstanding tags; results arriving afterwards SHALL be treated as orphans per REQ-012.

Configuration
REQ-018 With macro FFT_ARB_STATS_EN defined, the block SHALL add outputs stat_frames0 and stat_frames1, each 16 bits, counting FFT input transfers granted to requester 0 and 1 respectively, saturating at 16'hFFFF.
REQ-019 Without FFT_ARB_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-020 After reset, set req0_valid=req1_valid=1 continuously with fft_din_busy=0 -> grants alternate 0,1,0,1 and ptr toggles every cycle.
REQ-021 With TAG_DEPTH=4, fft_dout_valid=0 and both requesters valid -> 4 transfers, then fft_din_valid=0 and req0_busy=req1_busy=1.
REQ-022 Accept frames tagged 1,0,1, then return 3 results with rsp0_busy=rsp1_busy=0 -> rsp1, rsp0, rsp1 asserted in order with data passed unmodified.
REQ-023 Return a result while the FIFO is full and requesters are valid -> pop occurs, no push that cycle, and push resumes the next cycle.
REQ-024 Assert fft_dout_valid with an empty FIFO -> fft_dout_busy=0, no rsp valid, and err_orphan=1 until rst.
REQ-025 Hold rsp1_busy=1 while head tag=1 -> fft_dout_busy=1 and the result is held; after release, one transfer and one pop occur.
